kv_response_serializer: RTL

Transmit-side counterpart of the key-value byte receiver. It takes one completed key-value transaction (status code, kind, 32-bit key, 32-bit value) from the store and serializes it into a byte frame for the UART transmitter. The frame has a header, 4 key bytes and 4 value bytes, both MSB first, plus an optional XOR checksum. Bytes leave on a valid/ready handshake, and a toggle strobe mirrors the receiver's per-byte event style.

---
 rtl/kv_response_serializer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/kv_response_serializer.sv
// kv_response_serializer
// Takes one completed key-value transaction from the store and streams it
// to the UART transmitter as a byte frame. The frame is a header, the key
// MSB first, the value MSB first, and an optional XOR checksum. Bytes
// leave on a valid/ready handshake. An optional run of idle cycles can be
// placed between the bytes of one frame.
module kv_response_serializer #(
    parameter logic [3:0] HEADER_TAG    = 4'hA,
    parameter bit         SEND_CHECKSUM = 1'b1,
    parameter int         GAP_CYCLES    = 0
) (
    input  logic        tick_in,
    input  logic        rst,
    input  logic        resp_valid,
    output logic        resp_ready,
    input  logic [1:0]  signal,
    input  logic        transact_kind,
    input  logic [31:0] key,
    input  logic [31:0] transact_value,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        newbyt,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    // Index of the final byte: the checksum slot when it is sent, else the
    // last value byte.
    localparam logic [3:0] LAST_IDX = SEND_CHECKSUM ? 4'd9 : 4'd8;
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);
    localparam bit         USE_GAP  = (GAP_CYCLES > 0);

    state_t      state;
    logic [71:0] frame_reg;
    logic [3:0]  idx;
    logic [7:0]  gap_cnt;
    logic [7:0]  checksum;

    logic [7:0]  header;
    logic        accept;
    logic [3:0]  next_idx;
    logic [7:0]  next_chk;

    // Selects frame byte i from the captured header/key/value. Slot 9 is
    // the running checksum that the caller supplies.
    function automatic logic [7:0] pick_byte(input logic [71:0] frame,
                                             input logic [3:0]  i,
                                             input logic [7:0]  chk);
        logic [7:0] b;
        case (i)
            4'd0:    b = frame[71:64];
            4'd1:    b = frame[63:56];
            4'd2:    b = frame[55:48];
            4'd3:    b = frame[47:40];
            4'd4:    b = frame[39:32];
            4'd5:    b = frame[31:24];
            4'd6:    b = frame[23:16];
            4'd7:    b = frame[15:8];
            4'd8:    b = frame[7:0];
            default: b = chk;
        endcase
        return b;
    endfunction

    // The block takes a new transaction only while idle.
    assign resp_ready = (state == ST_IDLE);

    // Handshake decode and the values the next byte selection needs. The
    // checksum here already includes the byte currently being accepted.
    always_comb begin
        header   = {HEADER_TAG, signal, transact_kind, 1'b0};
        accept   = byte_valid && byte_ready;
        next_idx = idx + 4'd1;
        next_chk = checksum ^ byte_out;
    end

    // Frame sequencer. It captures a transaction, presents one byte at a
    // time, and advances on each accepted byte. The next byte is loaded
    // into byte_out on the same edge as the accept, so that with no gap a
    // byte can leave on every cycle.
    always_ff @(posedge tick_in) begin
        if (rst) begin
            state      <= ST_IDLE;
            frame_reg  <= '0;
            idx        <= '0;
            gap_cnt    <= '0;
            checksum   <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            newbyt     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (resp_valid) begin
                        frame_reg  <= {header, key, transact_value};
                        byte_out   <= header;
                        byte_valid <= 1'b1;
                        idx        <= '0;
                        checksum   <= '0;
                        state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (accept) begin
                        newbyt   <= ~newbyt;
                        checksum <= next_chk;
                        idx      <= next_idx;
                        if (idx == LAST_IDX) begin
                            byte_valid <= 1'b0;
                            frame_done <= 1'b1;
                            idx        <= '0;
                            checksum   <= '0;
                            state      <= ST_IDLE;
                        end else if (USE_GAP) begin
                            byte_valid <= 1'b0;
                            gap_cnt    <= GAP_LOAD;
                            state      <= ST_GAP;
                        end else begin
                            byte_out <= pick_byte(frame_reg, next_idx, next_chk);
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt <= 8'd1) begin
                        byte_out   <= pick_byte(frame_reg, idx, checksum);
                        byte_valid <= 1'b1;
                        state      <= ST_SEND;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: begin
                    byte_valid <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
